seqgen: RTL and testbench

- Serial pattern generator: the transmit end of the single-bit serial line consumed by the sequence detector (`seqdect`).
- On a start request it latches a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock, on `prtx`.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Used as the stimulus source for `seqdect` in system-level benches and as a reusable serial pattern source elsewhere.

---
 rtl/seqgen_if.sv | 17 +
 rtl/seqgen.sv | 80 ++++++++
 tb/tb_seqgen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seqgen_if.sv
// seqgen_if: control inputs and serial-line outputs of the seqgen pattern generator.
interface seqgen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] reps;
  logic [CNT_W-1:0] gap;
  logic             prtx;
  logic             busy;
  logic             frame;
  logic             done;
  modport master(output start, abort, pat, reps, gap, input prtx, busy, frame, done);
  modport slave(input start, abort, pat, reps, gap, output prtx, busy, frame, done);
endinterface

// File: rtl/seqgen.sv
// seqgen: serial pattern generator, shifts a latched pattern out MSB-first with repeats and idle gaps.
module seqgen #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input logic     clk,
  input logic     rst,
  seqgen_if.slave sg
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t           st, ns;
  logic [PAT_W-1:0] lp, lp_n;
  logic [CNT_W-1:0] rc, rc_n, lg, lg_n, gc, gc_n;
  logic [IW-1:0]    idx, idx_n;
  logic             prtx_q, busy_q, frame_q, done_q;
  always_comb begin
    ns    = st;
    lp_n  = lp;
    rc_n  = rc;
    lg_n  = lg;
    gc_n  = gc;
    idx_n = idx;
    case (st)
      IDLE: if (sg.start && !sg.abort) begin
        lp_n  = sg.pat;
        rc_n  = sg.reps;
        lg_n  = sg.gap;
        idx_n = TOP;
        ns    = (sg.reps == '0) ? DONE : SEND;
      end
      SEND: if (idx != '0) idx_n = idx - 1'b1;
      else begin
        rc_n  = (rc != '0) ? rc - 1'b1 : rc;
        idx_n = TOP;
        gc_n  = lg;
        ns    = (rc_n == '0) ? DONE : (lg != '0) ? GAP : SEND;
      end
      GAP: begin
        gc_n  = (gc != '0) ? gc - 1'b1 : gc;
        idx_n = TOP;
        ns    = (gc_n == '0) ? SEND : GAP;
      end
      DONE: ns = IDLE;
    endcase
    if (sg.abort) ns = IDLE;
  end
  // Outputs are decoded from the next state so they line up with the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      lp      <= '0;
      rc      <= '0;
      lg      <= '0;
      gc      <= '0;
      idx     <= '0;
      prtx_q  <= IDLE_LVL;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st      <= ns;
      lp      <= lp_n;
      rc      <= rc_n;
      lg      <= lg_n;
      gc      <= gc_n;
      idx     <= idx_n;
      prtx_q  <= (ns == SEND) ? lp_n[idx_n] : IDLE_LVL;
      busy_q  <= (ns == SEND) || (ns == GAP);
      frame_q <= (ns == SEND);
      done_q  <= (ns == DONE);
    end
  end
  assign sg.prtx  = prtx_q;
  assign sg.busy  = busy_q;
  assign sg.frame = frame_q;
  assign sg.done  = done_q;
endmodule

// File: tb/tb_seqgen.sv
// tb_seqgen: vector table, corner-case sequences and random traffic against a queue-based reference model.
module tb_seqgen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] q[$];
  logic       last_done = 1'b0;
  logic [3:0] exp_m;
  typedef struct {
    logic       s;
    logic [3:0] p, r, g;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  seqgen_if #(.PAT_W(4), .CNT_W(4)) sg();
  seqgen #(.PAT_W(4), .CNT_W(4), .IDLE_LVL(1'b0)) dut(.clk(clk), .rst(rst), .sg(sg));

  task automatic chk(string nm, logic [3:0] exp);
    logic [3:0] act;
    act = {sg.prtx, sg.busy, sg.frame, sg.done};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got prtx/busy/frame/done=%b, expected %b", nm, act, exp);
    end
  endtask

  // Whole transfer expanded into its per-cycle output tuples {prtx,busy,frame,done}.
  task automatic model(logic s, logic a, logic [3:0] p, logic [3:0] r, logic [3:0] g);
    if (a) begin
      q.delete();
      exp_m = 4'b0000;
    end else begin
      if (s && q.size() == 0 && !last_done) begin
        for (int k = 0; k < int'(r); k++) begin
          for (int b = 3; b >= 0; b--) q.push_back({p[b], 3'b110});
          if (k < int'(r) - 1) for (int j = 0; j < int'(g); j++) q.push_back(4'b0100);
        end
        q.push_back(4'b0001);
      end
      exp_m = (q.size() != 0) ? q.pop_front() : 4'b0000;
    end
    last_done = exp_m[0];
  endtask

  task automatic step(string nm, logic s, logic a, logic [3:0] p, logic [3:0] r, logic [3:0] g);
    sg.start = s;
    sg.abort = a;
    sg.pat   = p;
    sg.reps  = r;
    sg.gap   = g;
    @(posedge clk);
    model(s, a, p, r, g);
    #1 chk(nm, exp_m);
  endtask

  initial begin
    sg.start = 1'b0;
    sg.abort = 1'b0;
    sg.pat   = '0;
    sg.reps  = '0;
    sg.gap   = '0;
    tbl[0] = '{1'b1, 4'b0101, 4'd1, 4'd0, 4'b0110};
    tbl[1] = '{1'b0, 4'b0101, 4'd1, 4'd0, 4'b1110};
    tbl[2] = '{1'b0, 4'b0101, 4'd1, 4'd0, 4'b0110};
    tbl[3] = '{1'b0, 4'b0101, 4'd1, 4'd0, 4'b1110};
    tbl[4] = '{1'b0, 4'b0101, 4'd1, 4'd0, 4'b0001};
    tbl[5] = '{1'b0, 4'b0101, 4'd1, 4'd0, 4'b0000};
    tbl[6] = '{1'b1, 4'b0101, 4'd0, 4'd0, 4'b0001};
    tbl[7] = '{1'b1, 4'b0101, 4'd1, 4'd0, 4'b0000};
    tbl[8] = '{1'b0, 4'b0101, 4'd1, 4'd0, 4'b0000};
    #1 rst = 1'b0;
    #2 chk("reset", 4'b0000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step($sformatf("vec%0d_model", i), tbl[i].s, 1'b0, tbl[i].p, tbl[i].r, tbl[i].g);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    step("s2", 1'b1, 1'b0, 4'b1010, 4'd3, 4'd0);
    repeat (14) step("s2", 1'b0, 1'b0, 4'b0000, 4'd0, 4'd0);
    step("s3", 1'b1, 1'b0, 4'b0101, 4'd2, 4'd2);
    repeat (12) step("s3", 1'b0, 1'b0, 4'b1111, 4'd7, 4'd7);
    step("s5", 1'b1, 1'b0, 4'b1010, 4'd3, 4'd0);
    step("s5", 1'b0, 1'b0, 4'b1010, 4'd3, 4'd0);
    step("s5_start_busy", 1'b1, 1'b0, 4'b1111, 4'd1, 4'd0);
    step("s5_abort_model", 1'b0, 1'b1, 4'b1010, 4'd3, 4'd0);
    chk("s5_abort", 4'b0000);
    repeat (12) step("s5_after", 1'b0, 1'b0, 4'b1010, 4'd3, 4'd0);
    step("abort_start", 1'b1, 1'b1, 4'b1010, 4'd3, 4'd0);
    chk("abort_start_drop", 4'b0000);
    step("maxreps", 1'b1, 1'b0, 4'b1001, 4'd15, 4'd1);
    repeat (80) step("maxreps", 1'b0, 1'b0, 4'b0000, 4'd0, 4'd0);
    step("s6", 1'b1, 1'b0, 4'b0101, 4'd1, 4'd0);
    step("s6", 1'b0, 1'b0, 4'b0101, 4'd1, 4'd0);
    #3 rst = 1'b0;
    #1 chk("async_rst", 4'b0000);
    q.delete();
    last_done = 1'b0;
    @(posedge clk);
    #1 chk("rst_hold", 4'b0000);
    #2 rst = 1'b1;
    step("post_rst_idle", 1'b0, 1'b0, 4'b0101, 4'd1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("replay%0d_model", i), tbl[i].s, 1'b0, tbl[i].p, tbl[i].r, tbl[i].g);
      chk($sformatf("replay%0d", i), tbl[i].exp);
    end
    for (int i = 0; i < 3000; i++) begin
      logic s, a;
      logic [3:0] p, r, g;
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 59) == 0);
      p = 4'($urandom);
      r = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      g = 4'($urandom_range(0, 3));
      step("rand", s, a, p, r, g);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
